// File: rtl/fetch_responder.sv
// -----------------------------------------------------------------------------
// fetch_responder
//
// Responder end of the instruction-fetch req/ack/adr/dtr interface. Each
// request from the prefetch unit becomes one 16-bit word read on the external
// memory bus. The read has a programmable minimum number of wait states and a
// timeout. A one-entry last-word buffer lets a repeated address complete
// without touching memory.
//
// Handshake (prefetch side): req is a level. The requester raises req with adr
// stable and holds both until it sees ack, or drops req to abort. ack is a
// one-cycle pulse, and dtr/err are valid in that same cycle. dtr then holds
// its value until the next ack. Dropping req while the access is still waiting
// aborts it: no ack is produced and the buffer keeps its old contents.
// Handshake (memory side): mem_rd/mem_adr are held until the data is captured
// or the access is aborted or times out. mem_rdy is ignored until WS cycles
// have elapsed in WAIT.
//
// Parameters:
//   WS      minimum WAIT cycles before mem_rdy is honoured (0..15)
//   TMO     WAIT cycles without a capture before a bus-error response (> WS)
//   HIT_EN  non-zero enables last-word buffer hits
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   req, adr          fetch request level and 20-bit word address
//   ack, dtr, err     response pulse, read data, timeout flag
//   mem_rd, mem_adr   external read strobe and registered address
//   mem_rdy, mem_din  external data-valid and read data
//   inval             clears the last-word buffer
//   dbg_state         current FSM state (0=IDLE, 1=WAIT, 2=RESP)
// -----------------------------------------------------------------------------
module fetch_responder #(
    parameter int WS     = 1,
    parameter int TMO    = 64,
    parameter int HIT_EN = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic [19:0] adr,
    output logic        ack,
    output logic [15:0] dtr,
    output logic        err,
    output logic        mem_rd,
    output logic [19:0] mem_adr,
    input  logic        mem_rdy,
    input  logic [15:0] mem_din,
    input  logic        inval,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [7:0] WS_CNT   = 8'(WS);
    localparam logic [7:0] TMO_LAST = 8'(TMO - 1);
    localparam logic [7:0] CNT_MAX  = 8'hFF;

    // Registered state
    state_t      state;
    logic [7:0]  cnt;
    logic        buf_valid;
    logic [19:0] buf_adr;
    logic [15:0] buf_dat;

    // Next-state values
    state_t      state_n;
    logic [7:0]  cnt_n;
    logic        buf_valid_n;
    logic [19:0] buf_adr_n;
    logic [15:0] buf_dat_n;
    logic        ack_n;
    logic        err_n;
    logic [15:0] dtr_n;
    logic        mem_rd_n;
    logic [19:0] mem_adr_n;

    logic        hit;
    logic        rdy_ok;

    // A hit is judged only against the registered buffer contents, so an
    // inval on the same edge as a hit does not cancel that hit.
    assign hit       = (HIT_EN != 0) && buf_valid && (adr == buf_adr);
    assign rdy_ok    = mem_rdy && (cnt >= WS_CNT);
    assign dbg_state = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= 8'd0;
            buf_valid <= 1'b0;
            buf_adr   <= 20'd0;
            buf_dat   <= 16'd0;
            ack       <= 1'b0;
            err       <= 1'b0;
            dtr       <= 16'd0;
            mem_rd    <= 1'b0;
            mem_adr   <= 20'd0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            buf_valid <= buf_valid_n;
            buf_adr   <= buf_adr_n;
            buf_dat   <= buf_dat_n;
            ack       <= ack_n;
            err       <= err_n;
            dtr       <= dtr_n;
            mem_rd    <= mem_rd_n;
            mem_adr   <= mem_adr_n;
        end
    end

    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        // inval clears the buffer in any state; a capture below overrides it.
        buf_valid_n = buf_valid & ~inval;
        buf_adr_n   = buf_adr;
        buf_dat_n   = buf_dat;
        ack_n       = 1'b0;
        err_n       = 1'b0;
        dtr_n       = dtr;
        mem_rd_n    = mem_rd;
        mem_adr_n   = mem_adr;

        unique case (state)
            IDLE: begin
                if (req) begin
                    if (hit) begin
                        ack_n   = 1'b1;
                        dtr_n   = buf_dat;
                        state_n = RESP;
                    end else begin
                        mem_adr_n = adr;
                        mem_rd_n  = 1'b1;
                        cnt_n     = 8'd0;
                        state_n   = WAIT;
                    end
                end
            end

            WAIT: begin
                // Priority: abort, then capture, then timeout, then count.
                if (!req) begin
                    mem_rd_n = 1'b0;
                    state_n  = IDLE;
                end else if (rdy_ok) begin
                    dtr_n       = mem_din;
                    buf_adr_n   = mem_adr;
                    buf_dat_n   = mem_din;
                    buf_valid_n = 1'b1;
                    mem_rd_n    = 1'b0;
                    ack_n       = 1'b1;
                    state_n     = RESP;
                end else if (cnt == TMO_LAST) begin
                    dtr_n       = 16'hFFFF;
                    err_n       = 1'b1;
                    ack_n       = 1'b1;
                    mem_rd_n    = 1'b0;
                    buf_valid_n = 1'b0;
                    state_n     = RESP;
                end else begin
                    // Saturate rather than wrap so a stalled count cannot
                    // fall back below WS.
                    cnt_n = (cnt == CNT_MAX) ? cnt : cnt + 8'd1;
                end
            end

            RESP: begin
                // ack/err default low, so the pulse lasts exactly one cycle.
                state_n = IDLE;
            end

            default: begin
                state_n  = IDLE;
                mem_rd_n = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_fetch_responder.sv
module tb_fetch_responder;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        req = 1'b0;
    logic [19:0] adr = 20'd0;
    logic        ack;
    logic [15:0] dtr;
    logic        err;
    logic        mem_rd;
    logic [19:0] mem_adr;
    logic        mem_rdy = 1'b0;
    logic [15:0] mem_din;
    logic        inval = 1'b0;
    logic [1:0]  dbg_state;

    // Memory data: either a fixed driven word or a simple address-derived model.
    logic [15:0] mem_din_drv = 16'd0;
    logic        model_mode = 1'b0;
    assign mem_din = model_mode ? (16'hA000 + mem_adr[15:0]) : mem_din_drv;

    fetch_responder #(.WS(1), .TMO(64), .HIT_EN(1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .adr       (adr),
        .ack       (ack),
        .dtr       (dtr),
        .err       (err),
        .mem_rd    (mem_rd),
        .mem_adr   (mem_adr),
        .mem_rdy   (mem_rdy),
        .mem_din   (mem_din),
        .inval     (inval),
        .dbg_state (dbg_state)
    );

    // ---------------- scoreboard ----------------
    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [19:0] a;
        logic [15:0] d;
        logic        rdy;
        logic        pre_inval;
        int          exp_lat;
        int          exp_rd;
        logic [15:0] exp_dtr;
        logic        exp_err;
    } vec_t;

    // ---------------- driver tasks ----------------
    // Called right after a posedge (+#1) with the DUT in IDLE. Latency counts
    // edges from raising req: a miss with WS=1 and mem_rdy=1 acks at lat 3,
    // a hit at lat 1, a timeout at lat 65.
    task automatic run_vec(input vec_t v, input string tag);
        int          lat;
        int          rd_cyc;
        logic        got_ack;
        logic [19:0] got_madr;
        logic [15:0] got_dtr;
        logic        got_err;
        if (v.pre_inval) begin
            inval = 1'b1;
            @(posedge clk); #1;
            inval = 1'b0;
        end
        req = 1'b1; adr = v.a; mem_din_drv = v.d; mem_rdy = v.rdy;
        lat = 0; rd_cyc = 0; got_ack = 1'b0; got_madr = 20'd0;
        while (lat < 200) begin
            @(posedge clk); #1;
            lat++;
            if (mem_rd) begin
                rd_cyc++;
                got_madr = mem_adr;
            end
            if (ack) begin
                got_ack = 1'b1;
                break;
            end
        end
        got_dtr = dtr; got_err = err;
        req = 1'b0; mem_rdy = 1'b0;
        check({tag, "_ack_seen"}, 32'(got_ack), 32'd1);
        check({tag, "_latency"}, 32'(lat), 32'(v.exp_lat));
        check({tag, "_mem_rd_cycles"}, 32'(rd_cyc), 32'(v.exp_rd));
        check({tag, "_dtr"}, 32'(got_dtr), 32'(v.exp_dtr));
        check({tag, "_err"}, 32'(got_err), 32'(v.exp_err));
        if (v.exp_rd > 0) check({tag, "_mem_adr"}, 32'(got_madr), 32'(v.a));
        // RESP -> IDLE: pulse must end, dtr must hold.
        @(posedge clk); #1;
        check({tag, "_ack_pulse_end"}, 32'(ack), 32'd0);
        check({tag, "_err_pulse_end"}, 32'(err), 32'd0);
        check({tag, "_dtr_hold"}, 32'(dtr), 32'(v.exp_dtr));
        check({tag, "_idle"}, 32'(dbg_state), 32'd0);
    endtask

    vec_t vecs[9];
    vec_t hv;

    initial begin
        // {adr, mem_din, mem_rdy, pre_inval, lat, mem_rd cycles, dtr, err}
        vecs[0] = '{20'h00010, 16'hBEEF, 1'b1, 1'b0, 3, 2, 16'hBEEF, 1'b0}; // miss
        vecs[1] = '{20'h00010, 16'h1234, 1'b1, 1'b0, 1, 0, 16'hBEEF, 1'b0}; // hit
        vecs[2] = '{20'h00020, 16'hCAFE, 1'b1, 1'b0, 3, 2, 16'hCAFE, 1'b0}; // miss, replaces
        vecs[3] = '{20'h00010, 16'hAAAA, 1'b1, 1'b0, 3, 2, 16'hAAAA, 1'b0}; // old adr misses
        vecs[4] = '{20'h00010, 16'h0000, 1'b1, 1'b0, 1, 0, 16'hAAAA, 1'b0}; // hit
        vecs[5] = '{20'h00030, 16'h4321, 1'b0, 1'b0, 65, 64, 16'hFFFF, 1'b1}; // timeout
        vecs[6] = '{20'h00010, 16'h5555, 1'b1, 1'b0, 3, 2, 16'h5555, 1'b0}; // buf cleared by timeout
        vecs[7] = '{20'h00010, 16'h6666, 1'b1, 1'b1, 3, 2, 16'h6666, 1'b0}; // inval forces miss
        vecs[8] = '{20'h00010, 16'h0000, 1'b1, 1'b0, 1, 0, 16'h6666, 1'b0}; // hit again

        // ---- reset state ----
        repeat (2) @(posedge clk);
        #1;
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_dtr", 32'(dtr), 32'd0);
        check("rst_mem_rd", 32'(mem_rd), 32'd0);
        check("rst_mem_adr", 32'(mem_adr), 32'd0);
        check("rst_state", 32'(dbg_state), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // ---- table vectors ----
        for (int i = 0; i < 9; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // ---- abort in WAIT on the same edge mem_rdy rises ----
        req = 1'b1; adr = 20'h00040; mem_rdy = 1'b0; mem_din_drv = 16'h7777;
        @(posedge clk); #1;
        check("abort_mem_rd_up", 32'(mem_rd), 32'd1);
        @(posedge clk); #1;                 // cnt now reaches WS
        req = 1'b0; mem_rdy = 1'b1;
        @(posedge clk); #1;
        check("abort_mem_rd_down", 32'(mem_rd), 32'd0);
        check("abort_no_ack", 32'(ack), 32'd0);
        check("abort_idle", 32'(dbg_state), 32'd0);
        check("abort_dtr_kept", 32'(dtr), 32'h6666);
        mem_rdy = 1'b0;
        @(posedge clk); #1;
        check("abort_no_late_ack", 32'(ack), 32'd0);
        hv = '{20'h00010, 16'h0000, 1'b1, 1'b0, 1, 0, 16'h6666, 1'b0};
        run_vec(hv, "abort_buf_kept");
        hv = '{20'h00040, 16'h7777, 1'b1, 1'b0, 3, 2, 16'h7777, 1'b0};
        run_vec(hv, "abort_adr_misses");

        // ---- back-to-back, req held across addresses 0..3 ----
        begin
            int k;
            int cyc;
            int last;
            model_mode = 1'b1;
            req = 1'b1; adr = 20'd0; mem_rdy = 1'b1;
            k = 0; cyc = 0; last = 0;
            while (k < 4 && cyc < 100) begin
                @(posedge clk); #1;
                cyc++;
                if (ack) begin
                    check($sformatf("b2b_dtr%0d", k), 32'(dtr), 32'(16'hA000 + 16'(k)));
                    if (k == 0) check("b2b_first_lat", 32'(cyc), 32'd3);
                    else check($sformatf("b2b_spacing%0d", k), 32'(cyc - last), 32'd4);
                    last = cyc;
                    k++;
                    adr = 20'(k);
                end
            end
            check("b2b_ack_count", 32'(k), 32'd4);
            req = 1'b0; mem_rdy = 1'b0;
            @(posedge clk); #1;
            model_mode = 1'b0;
        end

        // ---- async reset mid-WAIT ----
        req = 1'b1; adr = 20'h00050; mem_rdy = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("pre_rst_mem_rd", 32'(mem_rd), 32'd1);
        rst_n = 1'b0;
        #1;
        check("async_rst_mem_rd", 32'(mem_rd), 32'd0);
        check("async_rst_ack", 32'(ack), 32'd0);
        check("async_rst_dtr", 32'(dtr), 32'd0);
        check("async_rst_state", 32'(dbg_state), 32'd0);
        req = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        hv = '{20'h00050, 16'h9999, 1'b1, 1'b0, 3, 2, 16'h9999, 1'b0};
        run_vec(hv, "post_rst");
        // Buffer was cleared by reset, so the earlier buffered address misses.
        hv = '{20'h00010, 16'h1111, 1'b1, 1'b0, 3, 2, 16'h1111, 1'b0};
        run_vec(hv, "post_rst_buf_empty");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_responder.md
Name: fetch_responder

Overview:
- Responder end of the instruction-fetch IO synchronisation interface (req/ack/adr/dtr).
- Services one 16-bit word read per request from the external memory bus, with programmable wait states and a timeout.
- Holds a one-entry last-word buffer so that a repeated address completes without a memory access.
- Sits between the prefetch unit and the memory/bus arbiter.

Parameters:
- WS, 1, minimum wait cycles after mem_rd is asserted before mem_rdy is honoured (0..15).
- TMO, 64, WAIT-state cycles with no accepted mem_rdy before a bus-error response (> WS).
- HIT_EN, 1, enables last-word buffer hits (0 = every request goes to memory).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req  in  1  level request from prefetch; held high until ack or abort.
- adr  in  20  word address; stable while req high.
- ack  out  1  one-cycle pulse; dtr valid in the same cycle.
- dtr  out  16  read data; holds its value until the next ack.
- err  out  1  high with ack when the response is a timeout (dtr = 16'hFFFF).
- mem_rd  out  1  external read strobe; held until data is captured or the access is aborted.
- mem_adr  out  20  external word address, registered.
- mem_rdy  in  1  external data-valid.
- mem_din  in  16  external read data.
- inval  in  1  clears the last-word buffer (self-modifying code or DMA write).

Behaviour:
- Reset values (async, rst_n low): ack=0, err=0, dtr=0, mem_rd=0, mem_adr=0, state=IDLE, cnt=0, buf_valid=0, buf_adr=0.
- States: IDLE, WAIT, RESP.
- IDLE, req=0: stay in IDLE.
- IDLE, req=1, HIT_EN and buf_valid and adr==buf_adr: go to RESP. ack=1 and dtr=buffered data after this edge. Latency 1 cycle.
- IDLE, req=1, otherwise: latch mem_adr<=adr, set mem_rd<=1 and cnt<=0, go to WAIT.
- WAIT, req=0 (abort): mem_rd<=0, go to IDLE. No ack. Buffer unchanged. Abort has priority over mem_rdy on the same edge.
- WAIT, mem_rdy=1 and cnt>=WS: dtr<=mem_din, buf_adr<=mem_adr, buf_valid<=1, mem_rd<=0, go to RESP with ack=1.
- mem_rdy while cnt<WS is ignored.
- WAIT, cnt==TMO-1 with no capture: dtr<=16'hFFFF, err<=1, ack<=1, mem_rd<=0, buf_valid<=0, go to RESP.
- WAIT, otherwise: cnt<=cnt+1. cnt is 8 bits and saturates; it never wraps.
- RESP: ack and err are high for exactly this cycle. The next edge clears both and goes to IDLE unconditionally.
- Back-to-back: if req is still high in IDLE (new adr), a new access starts. Each miss costs WS+3 cycles from the IDLE sample to the next IDLE.
- Miss latency: req sampled at edge E gives ack high after edge E+1+WS when mem_rdy is tied high.
- inval: buf_valid<=0 on any edge, in any state. If it coincides with a capture, the capture wins and buf_valid=1.
- A hit is tested only in IDLE, against the registered buf_adr/buf_valid.
- Async reset mid-WAIT drops mem_rd immediately. No ack is produced.
- dtr changes only on a capture, a hit load, a timeout, or reset.

Test Plan:
- WS=1, mem_rdy tied 1, req with adr=20'h00010 and mem_din=16'hBEEF: mem_rd high for 2 cycles, then ack pulses 1 cycle with dtr=16'hBEEF and err=0. ack goes high 3 edges after the req sample.
- Repeat the same adr after the first ack (HIT_EN=1): ack one edge after the IDLE sample, dtr=16'hBEEF, mem_rd stays 0. Pulse inval, then repeat the same adr: the access goes to memory (mem_rd asserted).
- Drop req in WAIT on the same edge mem_rdy rises: no ack, mem_rd falls, buffer keeps its old contents. The next request for that address misses.
- mem_rdy held 0, TMO=64: ack with err=1 and dtr=16'hFFFF exactly 64 cycles after WAIT entry. buf_valid=0 afterwards.
- Hold req high across 4 sequential addresses 0..3, mem_rdy=1, WS=1: 4 acks spaced 4 cycles apart with the correct data each.
- Assert rst_n=0 mid-WAIT: mem_rd, ack and dtr go to 0 immediately. After release, the first req is serviced normally.
